// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_run_ctrl
// Desc    : Load/run/halt sequencer for the single-cycle RISC-V CPU.
//           Optional macro SINGLE_STEP_EN adds step_mode/step control.
// Rev     : 1.0
// ============================================================================
module cpu_run_ctrl #(
  parameter int          AW          = 10,
  parameter logic [31:0] MAX_CYCLES  = 32'd1000000,
  parameter logic [31:0] EBREAK_WORD = 32'h00100073
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] load_len,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          cpu_en,
  input  logic [31:0]   instr,
`ifdef SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [23:0]   r_partial;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_count;
  logic          r_timeout;

  logic          w_is_ebreak;
  logic          w_words_left;
  logic          w_step_ok;
  logic [31:0]   w_count_next;

  assign w_is_ebreak  = (instr == EBREAK_WORD);
  assign w_words_left = (r_idx != r_len);

`ifdef SINGLE_STEP_EN
  logic r_step_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_step_prev <= 1'b0;
    else        r_step_prev <= step;
  end

  // In step mode only a fresh rising edge of step lets the CPU advance once.
  assign w_step_ok = !step_mode || (step && !r_step_prev);
`else
  assign w_step_ok = 1'b1;
`endif

  assign cpu_en       = (r_state == S_RUN) && !w_is_ebreak && w_step_ok;
  assign w_count_next = (cpu_en && (r_count != 32'hFFFF_FFFF)) ? r_count + 32'd1 : r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_lane    <= 2'd0;
      r_partial <= 24'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_count   <= 32'd0;
      r_timeout <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_len     <= load_len;
            r_idx     <= '0;
            r_lane    <= 2'd0;
            r_count   <= 32'd0;
            r_timeout <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Leaving only once the index has caught up puts the last write
          // cycle inside LOAD, so cpu_reset drops one cycle after it.
          if (!w_words_left) begin
            r_state <= S_RUN;
          end else if (rx_valid) begin
            if (r_lane == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_idx;
              r_wdata <= {rx_data, r_partial};
              r_idx   <= r_idx + 1'b1;
              r_lane  <= 2'd0;
            end else begin
              case (r_lane)
                2'd0:    r_partial[7:0]   <= rx_data;
                2'd1:    r_partial[15:8]  <= rx_data;
                default: r_partial[23:16] <= rx_data;
              endcase
              r_lane <= r_lane + 2'd1;
            end
          end
        end
        S_RUN: begin
          r_count <= w_count_next;
          if (w_is_ebreak) begin
            r_timeout <= 1'b0;
            r_state   <= S_HALT;
          end else if (w_count_next >= MAX_CYCLES) begin
            r_timeout <= 1'b1;
            r_state   <= S_HALT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready    = (r_state == S_LOAD) && w_words_left;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign cpu_reset   = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done        = (r_state == S_HALT);
  assign timeout     = r_timeout;
  assign cycle_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_run_ctrl
// Desc    : Self-checking bench for cpu_run_ctrl against a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_cpu_run_ctrl;
  localparam int          AW   = 4;
  localparam logic [31:0] MAXC = 32'd8;
  localparam logic [31:0] EBRK = 32'h00100073;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] load_len = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic [31:0]   instr = 32'h13;
  logic          rx_ready, imem_we, cpu_reset, cpu_en, busy, done, timeout;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, cycle_count;
`ifdef SINGLE_STEP_EN
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.AW(AW), .MAX_CYCLES(MAXC), .EBREAK_WORD(EBRK)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .instr(instr),
`ifdef SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  // Behavioural reference: modes named after the spec, bytes kept in a queue.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
  int              m_mode = M_IDLE;
  int unsigned     m_len = 0, m_words = 0, m_addr = 0;
  byte unsigned    m_bytes[$];
  longint unsigned m_count = 0;
  bit              m_to = 1'b0, m_we = 1'b0, m_step_prev = 1'b0;
  logic [31:0]     m_wdata = 32'd0;

  function automatic bit exp_en();
    bit ok;
    ok = 1'b1;
`ifdef SINGLE_STEP_EN
    ok = !step_mode || (step && !m_step_prev);
`endif
    return (m_mode == M_RUN) && (instr != EBRK) && ok;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit en;
    if (!reset) begin
      m_mode = M_IDLE; m_we = 1'b0; m_addr = 0; m_wdata = 32'd0;
      m_count = 0; m_to = 1'b0; m_step_prev = 1'b0; m_words = 0;
      m_bytes.delete();
    end else begin
      en = exp_en();
`ifdef SINGLE_STEP_EN
      m_step_prev = step;
`endif
      m_we = 1'b0;
      if (m_mode == M_IDLE || m_mode == M_HALT) begin
        if (start) begin
          m_len = load_len; m_words = 0; m_count = 0; m_to = 1'b0;
          m_bytes.delete(); m_mode = M_LOAD;
        end
      end else if (m_mode == M_LOAD) begin
        if (m_words == m_len) m_mode = M_RUN;
        else if (rx_valid) begin
          m_bytes.push_back(rx_data);
          if (m_bytes.size() == 4) begin
            m_we    = 1'b1;
            m_addr  = m_words % (2 ** AW);
            m_wdata = 32'(m_bytes[0]) | (32'(m_bytes[1]) << 8) |
                      (32'(m_bytes[2]) << 16) | (32'(m_bytes[3]) << 24);
            m_words++;
            m_bytes.delete();
          end
        end
      end else if (m_mode == M_RUN) begin
        if (en && m_count < 64'hFFFF_FFFF) m_count++;
        if (instr == EBRK) begin m_mode = M_HALT; m_to = 1'b0; end
        else if (m_count >= MAXC) begin m_mode = M_HALT; m_to = 1'b1; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [6:0] act, exp;
    act = {rx_ready, imem_we, cpu_reset, cpu_en, busy, done, timeout};
    exp = {(m_mode == M_LOAD) && (m_words != m_len), m_we,
           (m_mode == M_IDLE) || (m_mode == M_LOAD), exp_en(),
           (m_mode == M_LOAD) || (m_mode == M_RUN), m_mode == M_HALT, m_to};
    chk("ctrl", 32'(act), 32'(exp));
    chk("imem_addr", 32'(imem_addr), m_addr);
    chk("imem_wdata", imem_wdata, m_wdata);
    chk("cycle_count", cycle_count, 32'(m_count));
  endtask

  int          cyc = 0, last_hs = 0, fall_cyc = 0, en_seen = 0;
  logic        prev_cr = 1'b1;
  logic [31:0] wr_addr[$], wr_data[$];

  // One clock: compare and log on the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    if (rx_valid && rx_ready) last_hs = cyc;
    if (prev_cr && !cpu_reset) fall_cyc = cyc;
    prev_cr = cpu_reset;
    if (cpu_en) en_seen++;
    if (imem_we) begin wr_addr.push_back(32'(imem_addr)); wr_data.push_back(imem_wdata); end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input bit lit);
    reset = 1'b0;
    #1;
    if (lit) begin
      chk("rst_count", cycle_count, 32'd0);
      chk("rst_ctrl", 32'({rx_ready, imem_we, cpu_reset, cpu_en, busy, done, timeout}), 32'h10);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] len);
    load_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1; rx_data = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = rx_ready;
      tick();
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && !done; i++) tick();
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] prog[8];
    logic [7:0] t5[4];
    int base, n;
    bit aborted;
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    t5   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    #3 reset = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b1);

    // Load two words, then run three cycles into EBREAK.
    instr = 32'h00500513;
    pulse_start(AW'(2));
    foreach (prog[i]) send_byte(prog[i]);
    tick();
    tick(); tick(); tick();
    instr = EBRK;
    #1;
    chk("ebreak_cpu_en", 32'(cpu_en), 32'd0);
    tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_count", cycle_count, 32'd3);
    chk("t3_timeout", 32'(timeout), 32'd0);
    chk("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    chk("t2_addr0", wr_addr[0], 32'd0);
    chk("t2_data0", wr_data[0], 32'h00500513);
    chk("t2_addr1", wr_addr[1], 32'd1);
    chk("t2_data1", wr_data[1], 32'h00100073);
    chk("t2_rst_fall", 32'(fall_cyc - last_hs), 32'd2);

    // Watchdog expiry with an empty program.
    instr = 32'h13;
    base = en_seen;
    pulse_start(AW'(0));
    wait_done(40, "t4_halt_wait");
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_count", cycle_count, 32'd8);
    chk("t4_en_cycles", 32'(en_seen - base), 32'd8);
    pulse_start(AW'(1));
    chk("t4_reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t4_reload_done", 32'(done), 32'd0);

    // Reset mid-word, then a clean word must carry no stale lanes.
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset(1'b0);
    base = wr_data.size();
    pulse_start(AW'(1));
    foreach (t5[i]) send_byte(t5[i]);
    tick(); tick();
    chk("t5_nwrites", 32'(wr_data.size() - base), 32'd1);
    chk("t5_data", wr_data[base], 32'hDDCCBBAA);
    chk("t5_addr", wr_addr[base], 32'd0);

    // Asynchronous reset in the middle of a run.
    tick(); tick(); tick();
    chk("t1_running", 32'(cycle_count != 0), 32'd1);
    #2;
    do_reset(1'b1);

    // Randomized load/run sessions.
    for (int it = 0; it < 40; it++) begin
      aborted = 1'b0;
      if ($urandom_range(0, 9) == 0) do_reset(1'b0);
      n = $urandom_range(0, 5);
      pulse_start(AW'(n));
      for (int b = 0; b < n * 4 && !aborted; b++) begin
        repeat ($urandom_range(0, 2)) begin
          rx_valid = 1'b0;
          start = ($urandom_range(0, 3) == 0);
          load_len = AW'($urandom);
          tick();
        end
        start = 1'b0;
        if ($urandom_range(0, 40) == 0) begin
          do_reset(1'b0);
          aborted = 1'b1;
        end else begin
          send_byte(8'($urandom));
        end
      end
      if (!aborted) begin
        for (int c = 0; c < 60 && !done; c++) begin
          instr = ($urandom_range(0, 5) == 0) ? EBRK : $urandom;
          rx_valid = $urandom_range(0, 1) == 1;
          rx_data = 8'($urandom);
          tick();
        end
        rx_valid = 1'b0;
        chk("rand_halt_wait", 32'(done), 32'd1);
      end
    end

`ifdef SINGLE_STEP_EN
    begin
      int pat[14];
      pat = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
      instr = 32'h13;
      step_mode = 1'b1; step = 1'b0;
      pulse_start(AW'(0));
      tick(); tick();
      base = en_seen;
      foreach (pat[i]) begin
        step = pat[i][0];
        tick();
      end
      chk("t6_en_cycles", 32'(en_seen - base), 32'd3);
      chk("t6_count", cycle_count, 32'd3);
      step_mode = 1'b0;
    end
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
